// File: rtl/paicore_chip_echo.sv
`timescale 1ns / 1ps
// paicore_chip_echo: multi-channel 4-phase handshake echo. Frames accepted on
// any input channel are queued in one shared FIFO (round-robin arbitration
// among requesting channels). Each frame is then sent out on the next enabled
// output channel, also chosen round-robin.
// Optional build macro PAICORE_CHIP_ECHO_CNT_EN adds rx/tx frame counters.
module paicore_chip_echo #(
    parameter int Channel     = 4,
    parameter int FRAME_WIDTH = 32,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [Channel-1:0]               request,
    input  logic [Channel*FRAME_WIDTH-1:0]   din,
    output logic [Channel-1:0]               acknowledge,
    input  logic [Channel-1:0]               oen,
    output logic [Channel-1:0]               out_request,
    output logic [Channel*FRAME_WIDTH-1:0]   dout,
    input  logic [Channel-1:0]               out_acknowledge,
    output logic                             fifo_full,
    output logic                             fifo_empty
`ifdef PAICORE_CHIP_ECHO_CNT_EN
    ,
    output logic [31:0]                      rx_frame_cnt,
    output logic [31:0]                      tx_frame_cnt
`endif
);

    localparam int unsigned NCH = Channel;
    localparam int          CW  = (Channel > 1) ? $clog2(Channel) : 1;
    localparam int          AW  = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IN_IDLE,
        IN_ACK
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ,
        OUT_WAIT_LO
    } out_state_e;

    // Channel index "k places after base", wrapping at Channel.
    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int unsigned k);
        rr_idx = CW'((32'(base) + k) % NCH);
    endfunction

    // Input side
    in_state_e                 in_state_q [Channel];
    in_state_e                 in_state_d [Channel];
    logic [Channel-1:0]        ack_q, ack_d;
    logic [CW-1:0]             in_rr_q, in_rr_d;
    logic                      grant_found;
    logic [CW-1:0]             grant_idx;
    logic                      push;
    logic [FRAME_WIDTH-1:0]    push_data;

    // Frame buffer
    logic [FRAME_WIDTH-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW:0]               count_q, count_d;
    logic                      full_q, full_d;
    logic                      empty_q, empty_d;

    // Output side
    out_state_e                out_state_q, out_state_d;
    logic [CW-1:0]             out_ch_q, out_ch_d;
    logic [CW-1:0]             out_rr_q, out_rr_d;
    logic [Channel-1:0]        out_req_q, out_req_d;
    logic [Channel*FRAME_WIDTH-1:0] dout_q, dout_d;
    logic                      pop;
    logic                      sel_found;
    logic [CW-1:0]             out_sel;
    logic                      tx_done;

`ifdef PAICORE_CHIP_ECHO_CNT_EN
    logic [31:0]               rx_cnt_q, rx_cnt_d;
    logic [31:0]               tx_cnt_q, tx_cnt_d;
`endif

    // Round-robin grant among idle requesting channels; nothing granted while full.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (!full_q) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (!grant_found && request[rr_idx(in_rr_q, k)] &&
                    in_state_q[rr_idx(in_rr_q, k)] == IN_IDLE) begin
                    grant_found = 1'b1;
                    grant_idx   = rr_idx(in_rr_q, k);
                end
            end
        end
        push      = grant_found;
        push_data = din[grant_idx*FRAME_WIDTH +: FRAME_WIDTH];
        in_rr_d   = push ? rr_idx(grant_idx, 1) : in_rr_q;
    end

    // Per-channel input handshake FSMs.
    always_comb begin
        ack_d = ack_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            in_state_d[i] = in_state_q[i];
            case (in_state_q[i])
                IN_IDLE: begin
                    if (push && grant_idx == CW'(i)) begin
                        in_state_d[i] = IN_ACK;
                        ack_d[i]      = 1'b1;
                    end
                end
                IN_ACK: begin
                    if (!request[i]) begin
                        in_state_d[i] = IN_IDLE;
                        ack_d[i]      = 1'b0;
                    end
                end
                default: in_state_d[i] = IN_IDLE;
            endcase
        end
    end

    // Next enabled output channel after the last one used.
    always_comb begin
        sel_found = 1'b0;
        out_sel   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!sel_found && oen[rr_idx(out_rr_q, k)]) begin
                sel_found = 1'b1;
                out_sel   = rr_idx(out_rr_q, k);
            end
        end
    end

    // Output handshake FSM; the frame leaves the buffer when its channel is chosen.
    always_comb begin
        out_state_d = out_state_q;
        out_ch_d    = out_ch_q;
        out_rr_d    = out_rr_q;
        out_req_d   = out_req_q;
        dout_d      = dout_q;
        pop         = 1'b0;
        tx_done     = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (!empty_q && sel_found) begin
                    pop                                           = 1'b1;
                    out_state_d                                   = OUT_REQ;
                    out_ch_d                                      = out_sel;
                    out_rr_d                                      = rr_idx(out_sel, 1);
                    out_req_d                                     = '0;
                    out_req_d[out_sel]                            = 1'b1;
                    dout_d                                        = '0;
                    dout_d[out_sel*FRAME_WIDTH +: FRAME_WIDTH]    = mem[rd_ptr_q];
                end
            end
            OUT_REQ: begin
                if (out_acknowledge[out_ch_q]) begin
                    out_req_d   = '0;
                    out_state_d = OUT_WAIT_LO;
                end
            end
            OUT_WAIT_LO: begin
                if (!out_acknowledge[out_ch_q]) begin
                    out_state_d = OUT_IDLE;
                    tx_done     = 1'b1;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    // Buffer pointers, occupancy and registered status flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        full_d   = (count_d == (AW+1)'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
    end

`ifdef PAICORE_CHIP_ECHO_CNT_EN
    // Frame counters: one per accepted push, one per completed output handshake.
    always_comb begin
        rx_cnt_d = rx_cnt_q + 32'(push);
        tx_cnt_d = tx_cnt_q + 32'(tx_done);
    end
`endif

    // Frame storage write port (contents need no reset).
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                in_state_q[i] <= IN_IDLE;
            end
            ack_q       <= '0;
            in_rr_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            out_state_q <= OUT_IDLE;
            out_ch_q    <= '0;
            out_rr_q    <= '0;
            out_req_q   <= '0;
            dout_q      <= '0;
`ifdef PAICORE_CHIP_ECHO_CNT_EN
            rx_cnt_q    <= '0;
            tx_cnt_q    <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                in_state_q[i] <= in_state_d[i];
            end
            ack_q       <= ack_d;
            in_rr_q     <= in_rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            out_state_q <= out_state_d;
            out_ch_q    <= out_ch_d;
            out_rr_q    <= out_rr_d;
            out_req_q   <= out_req_d;
            dout_q      <= dout_d;
`ifdef PAICORE_CHIP_ECHO_CNT_EN
            rx_cnt_q    <= rx_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
`endif
        end
    end

    assign acknowledge = ack_q;
    assign out_request = out_req_q;
    assign dout        = dout_q;
    assign fifo_full   = full_q;
    assign fifo_empty  = empty_q;
`ifdef PAICORE_CHIP_ECHO_CNT_EN
    assign rx_frame_cnt = rx_cnt_q;
    assign tx_frame_cnt = tx_cnt_q;
`endif

endmodule

// File: tb/tb_paicore_chip_echo.sv
`timescale 1ns / 1ps
// Directed bench for paicore_chip_echo (4 channels, 32-bit frames, depth 16).
module tb_paicore_chip_echo;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   request;
    logic [127:0] din;
    logic [3:0]   acknowledge;
    logic [3:0]   oen;
    logic [3:0]   out_request;
    logic [127:0] dout;
    logic [3:0]   out_acknowledge;
    logic         fifo_full;
    logic         fifo_empty;
`ifdef PAICORE_CHIP_ECHO_CNT_EN
    logic [31:0]  rx_frame_cnt;
    logic [31:0]  tx_frame_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int onehot_viol  = 0;

    paicore_chip_echo #(
        .Channel     (4),
        .FRAME_WIDTH (32),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .request         (request),
        .din             (din),
        .acknowledge     (acknowledge),
        .oen             (oen),
        .out_request     (out_request),
        .dout            (dout),
        .out_acknowledge (out_acknowledge),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty)
`ifdef PAICORE_CHIP_ECHO_CNT_EN
        ,
        .rx_frame_cnt    (rx_frame_cnt),
        .tx_frame_cnt    (tx_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    // At most one out_request bit may ever be high.
    always @(negedge clk) begin
        if (!rst && $countones(out_request) > 1) begin
            onehot_viol++;
            $display("FAIL onehot: out_request=%b", out_request);
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  oack;
        logic [3:0]  exp_ack;
        logic [3:0]  exp_oreq;
        logic        chk_dout;
        logic [31:0] exp_dout0;
        logic        exp_empty;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        request         = '0;
        din             = '0;
        oen             = '0;
        out_acknowledge = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_frame(input int ch, input logic [31:0] data);
        int n;
        din[ch*32 +: 32] = data;
        request[ch]      = 1'b1;
        n = 0;
        while (!acknowledge[ch] && n < 50) begin tick(); n++; end
        check("send_ack", 128'(acknowledge[ch]), 128'd1);
        request[ch] = 1'b0;
        n = 0;
        while (acknowledge[ch] && n < 50) begin tick(); n++; end
        check("send_ack_drop", 128'(acknowledge[ch]), 128'd0);
    endtask

    task automatic recv_frame(input int ch, input logic [31:0] data);
        int n;
        n = 0;
        while (out_request == '0 && n < 50) begin tick(); n++; end
        check("recv_req", 128'(out_request), 128'(4'b0001 << ch));
        check("recv_data", 128'(dout[ch*32 +: 32]), 128'(data));
        out_acknowledge[ch] = 1'b1;
        n = 0;
        while (out_request != '0 && n < 50) begin tick(); n++; end
        check("recv_req_drop", 128'(out_request), 128'd0);
        out_acknowledge[ch] = 1'b0;
        tick();
    endtask

    initial begin
        int   n;
        logic seen_ack;

        // Reset state
        rst = 1'b1; request = '0; din = '0; oen = '0; out_acknowledge = '0;
        tick();
        check("rst_ack", 128'(acknowledge), 128'd0);
        check("rst_oreq", 128'(out_request), 128'd0);
        check("rst_dout", dout, 128'd0);
        check("rst_empty", 128'(fifo_empty), 128'd1);
        check("rst_full", 128'(fifo_full), 128'd0);
        rst = 1'b0;
        tick();

        // Single frame, cycle by cycle
        vecs[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1, 32'h0,        1'b0};
        vecs[1] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b1, 32'h12345678, 1'b1};
        vecs[2] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1, 32'h12345678, 1'b1};
        vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,        1'b1};
        vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,        1'b1};
        oen        = 4'b0001;
        din[31:0]  = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            request         = vecs[i].req;
            out_acknowledge = vecs[i].oack;
            tick();
            check("single_ack", 128'(acknowledge), 128'(vecs[i].exp_ack));
            check("single_oreq", 128'(out_request), 128'(vecs[i].exp_oreq));
            if (vecs[i].chk_dout) check("single_dout", 128'(dout[31:0]), 128'(vecs[i].exp_dout0));
            check("single_empty", 128'(fifo_empty), 128'(vecs[i].exp_empty));
        end

        // Contention: all four request at once
        do_reset();
        oen = 4'b0001;
        for (int c = 0; c < 4; c++) din[c*32 +: 32] = 32'hA0 + 32'(c);
        request = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("contend_ack", 128'(acknowledge), 128'((5'b00001 << (k + 1)) - 5'd1));
        end
        request = '0;
        tick();
        check("contend_ack_drop", 128'(acknowledge), 128'd0);
        for (int c = 0; c < 4; c++) recv_frame(0, 32'hA0 + 32'(c));

        // Spread over oen=1010
        do_reset();
        oen = 4'b1010;
        for (int i = 0; i < 4; i++) send_frame(0, 32'hE0 + 32'(i));
        recv_frame(1, 32'hE0);
        recv_frame(3, 32'hE1);
        recv_frame(1, 32'hE2);
        recv_frame(3, 32'hE3);

        // Full buffer: 16 accepted, 17th held off
        do_reset();
        oen = 4'b0000;
        for (int i = 0; i < 16; i++) send_frame(2, 32'hF000_0000 + 32'(i));
        check("full_flag", 128'(fifo_full), 128'd1);
        check("full_not_empty", 128'(fifo_empty), 128'd0);
        din[64 +: 32] = 32'hF000_0010;
        request[2]    = 1'b1;
        seen_ack      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_ack |= acknowledge[2];
        end
        check("full_withheld", 128'(seen_ack), 128'd0);
        oen = 4'b0100;
        recv_frame(2, 32'hF000_0000);
        n = 0;
        while (!acknowledge[2] && n < 50) begin tick(); n++; end
        check("full_17th_ack", 128'(acknowledge[2]), 128'd1);
        request[2] = 1'b0;
        n = 0;
        while (acknowledge[2] && n < 50) begin tick(); n++; end
        for (int i = 1; i < 17; i++) recv_frame(2, 32'hF000_0000 + 32'(i));
        tick();
        check("drain_empty", 128'(fifo_empty), 128'd1);

        // Reset mid-operation
        do_reset();
        oen = 4'b0000;
        for (int i = 0; i < 4; i++) send_frame(0, 32'hB0 + 32'(i));
        din[32 +: 32] = 32'hC1;
        request[1]    = 1'b1;
        n = 0;
        while (!acknowledge[1] && n < 50) begin tick(); n++; end
        check("mid_ack1", 128'(acknowledge), 128'b0010);
        rst = 1'b1;
        #1;
        check("mid_rst_ack", 128'(acknowledge), 128'd0);
        check("mid_rst_oreq", 128'(out_request), 128'd0);
        check("mid_rst_dout", dout, 128'd0);
        check("mid_rst_empty", 128'(fifo_empty), 128'd1);
        check("mid_rst_full", 128'(fifo_full), 128'd0);
        tick();
        rst = 1'b0;
        n = 0;
        while (!acknowledge[1] && n < 50) begin tick(); n++; end
        check("post_rst_ack1", 128'(acknowledge[1]), 128'd1);
        request[1] = 1'b0;
        n = 0;
        while (acknowledge[1] && n < 50) begin tick(); n++; end
        oen = 4'b0010;
        recv_frame(1, 32'hC1);
        tick();
        tick();
        check("post_rst_empty", 128'(fifo_empty), 128'd1);
        check("post_rst_quiet", 128'(out_request), 128'd0);

`ifdef PAICORE_CHIP_ECHO_CNT_EN
        // Frame counters over 10 looped frames
        do_reset();
        oen = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            send_frame(0, 32'hD0 + 32'(i));
            recv_frame(0, 32'hD0 + 32'(i));
        end
        check("rx_cnt", 128'(rx_frame_cnt), 128'd10);
        check("tx_cnt", 128'(tx_frame_cnt), 128'd10);
`endif

        check("onehot_total", 128'(onehot_viol), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
